// File: rtl/flog_front_end.sv
// flog_front_end: bfloat16 log2 input stage. Resolves IEEE special operands locally and hands the rest to the log core.
// Optional macro FLOG_TIMEOUT_EN adds a WAIT_CORE watchdog that returns qNaN with err_o set.
`default_nettype none

module flog_front_end #(
   parameter int EXP_WIDTH   = 8,
   parameter int FRACT_WIDTH = 7,
   parameter int BIAS        = 127,
   parameter int TIMEOUT     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [15:0]            op_i,
   output logic                   core_sign_o,
   output logic [EXP_WIDTH-1:0]   core_exp_o,
   output logic [FRACT_WIDTH-1:0] core_fract_o,
   output logic                   core_valid_o,
   input  logic                   core_s_i,
   input  logic [EXP_WIDTH-1:0]   core_e_i,
   input  logic [FRACT_WIDTH-1:0] core_f_i,
   input  logic                   core_valid_i,
   output logic [15:0]            res_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   special_o,
   output logic                   err_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CORE, HOLD} state_t;

   localparam logic [EXP_WIDTH-1:0]   EXP_ONES  = {EXP_WIDTH{1'b1}};
   localparam logic [EXP_WIDTH-1:0]   EXP_ONE   = BIAS[EXP_WIDTH-1:0];
   localparam logic [FRACT_WIDTH-1:0] QUIET_BIT = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
   localparam logic [15:0]            QNAN      = {1'b0, EXP_ONES, QUIET_BIT};
   localparam logic [15:0]            NEG_INF   = {1'b1, EXP_ONES, {FRACT_WIDTH{1'b0}}};
   localparam logic [15:0]            POS_INF   = {1'b0, EXP_ONES, {FRACT_WIDTH{1'b0}}};

   state_t                 state_q, state_d;
   logic [15:0]            res_q, res_d;
   logic                   special_q, special_d;
   logic                   err_q, err_d;
   logic                   csign_q, csign_d;
   logic [EXP_WIDTH-1:0]   cexp_q, cexp_d;
   logic [FRACT_WIDTH-1:0] cfract_q, cfract_d;

   logic                   op_sign;
   logic [EXP_WIDTH-1:0]   op_exp;
   logic [FRACT_WIDTH-1:0] op_fract;
   logic                   is_special;
   logic [15:0]            special_res;
   logic                   timeout;

   assign op_sign  = op_i[15];
   assign op_exp   = op_i[14 -: EXP_WIDTH];
   assign op_fract = op_i[FRACT_WIDTH-1:0];

   // Priority order matters: NaN beats sign, zero/denormal beats sign.
   always_comb begin
      is_special  = 1'b1;
      special_res = 16'h0000;
      if (op_exp == EXP_ONES && op_fract != '0)
         special_res = {1'b0, EXP_ONES, op_fract | QUIET_BIT};
      else if (op_exp == '0)
         special_res = NEG_INF;
      else if (op_sign)
         special_res = QNAN;
      else if (op_exp == EXP_ONES)
         special_res = POS_INF;
      else if (op_exp == EXP_ONE && op_fract == '0)
         special_res = 16'h0000;
      else
         is_special = 1'b0;
   end

`ifdef FLOG_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Held at zero outside WAIT_CORE so it is already clear on entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == WAIT_CORE) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      special_d = special_q;
      err_d     = err_q;
      csign_d   = csign_q;
      cexp_d    = cexp_q;
      cfract_d  = cfract_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               special_d = is_special;
               err_d     = 1'b0;
               if (is_special) begin
                  res_d   = special_res;
                  state_d = HOLD;
               end else begin
                  csign_d  = op_sign;
                  cexp_d   = op_exp;
                  cfract_d = op_fract;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: state_d = WAIT_CORE;
         WAIT_CORE: begin
            // A core result in the expiry cycle wins over the watchdog.
            if (core_valid_i) begin
               res_d     = {core_s_i, core_e_i, core_f_i};
               special_d = 1'b0;
               err_d     = 1'b0;
               state_d   = HOLD;
            end else if (timeout) begin
               res_d     = QNAN;
               special_d = 1'b0;
               err_d     = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         res_q     <= '0;
         special_q <= 1'b0;
         err_q     <= 1'b0;
         csign_q   <= 1'b0;
         cexp_q    <= '0;
         cfract_q  <= '0;
      end else begin
         state_q   <= state_d;
         res_q     <= res_d;
         special_q <= special_d;
         err_q     <= err_d;
         csign_q   <= csign_d;
         cexp_q    <= cexp_d;
         cfract_q  <= cfract_d;
      end
   end

   assign ready_o      = (state_q == IDLE) && rst;
   assign core_valid_o = (state_q == ISSUE);
   assign valid_o      = (state_q == HOLD);
   assign res_o        = res_q;
   assign special_o    = special_q;
   assign err_o        = err_q;
   assign core_sign_o  = csign_q;
   assign core_exp_o   = cexp_q;
   assign core_fract_o = cfract_q;

endmodule

`default_nettype wire
